// File: rtl/lsu_ri12_pkg.sv
// Shared opcode, exception and state encodings for the 2RI12 load/store unit,
// plus small helpers used by the FSM and the alignment network.
package lsu_ri12_pkg;

    localparam int XLEN = 32;

    localparam logic [7:0] ALU_LDB  = 8'h40;
    localparam logic [7:0] ALU_LDH  = 8'h41;
    localparam logic [7:0] ALU_LDW  = 8'h42;
    localparam logic [7:0] ALU_LDBU = 8'h43;
    localparam logic [7:0] ALU_LDHU = 8'h44;
    localparam logic [7:0] ALU_STB  = 8'h45;
    localparam logic [7:0] ALU_STH  = 8'h46;
    localparam logic [7:0] ALU_STW  = 8'h47;
    localparam logic [7:0] ALU_ORI  = 8'h0c;

    localparam logic [6:0] EXCEPTION_ALE = 7'h09;
    localparam logic [6:0] EXCEPTION_INE = 7'h0d;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            reg_write_en;
        logic [4:0]      reg_write_addr;
        logic [XLEN-1:0] reg_write_data;
        logic            is_exception;
        logic [6:0]      exception_cause;
        logic [XLEN-1:0] badv;
    } wb_pkt_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == ALU_LDB) || (op == ALU_LDH) || (op == ALU_LDW) ||
               (op == ALU_LDBU) || (op == ALU_LDHU);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == ALU_STB) || (op == ALU_STH) || (op == ALU_STW);
    endfunction

    function automatic logic op_legal(input logic [7:0] op);
        return is_load_op(op) || is_store_op(op);
    endfunction

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

    function automatic wb_pkt_t make_pkt(
        input logic [XLEN-1:0] pc,
        input logic            we,
        input logic [4:0]      waddr,
        input logic [XLEN-1:0] wdata,
        input logic            exc,
        input logic [6:0]      cause,
        input logic [XLEN-1:0] badv
    );
        wb_pkt_t p;
        p.pc              = pc;
        p.reg_write_en    = we;
        p.reg_write_addr  = waddr;
        p.reg_write_data  = wdata;
        p.is_exception    = exc;
        p.exception_cause = cause;
        p.badv            = badv;
        return p;
    endfunction

endpackage

// File: rtl/lsu_ri12_align.sv
// Byte-lane network: store strobes/replicated data, load extraction/extension,
// and the misalignment flag for a given op and low address bits.
module lsu_align
    import lsu_ri12_pkg::*;
(
    input  logic [7:0]      op,
    input  logic [1:0]      ea_lo,
    input  logic [XLEN-1:0] rd_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    logic [XLEN-1:0] shifted;

    // Addressed byte/half lands in the low lanes for extraction.
    assign shifted = rdata >> {ea_lo, 3'b000};

    always_comb begin
        wstrb     = 4'b0000;
        wdata     = '0;
        load_data = '0;
        misalign  = 1'b0;
        case (op)
            ALU_LDB:  load_data = sext8(shifted[7:0]);
            ALU_LDBU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            ALU_LDH: begin
                misalign  = ea_lo[0];
                load_data = sext16(shifted[15:0]);
            end
            ALU_LDHU: begin
                misalign  = ea_lo[0];
                load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            end
            ALU_LDW: begin
                misalign  = |ea_lo;
                load_data = rdata;
            end
            ALU_STB: begin
                wstrb = 4'b0001 << ea_lo;
                wdata = {4{rd_data[7:0]}};
            end
            ALU_STH: begin
                misalign = ea_lo[0];
                wstrb    = 4'b0011 << ea_lo;
                wdata    = {2{rd_data[15:0]}};
            end
            ALU_STW: begin
                misalign = |ea_lo;
                wstrb    = 4'b1111;
                wdata    = rd_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ri12.sv
// Single-outstanding load/store unit for 2RI12 memory ops: address generation,
// alignment check, dcache valid/ready request, load extend and writeback.
module lsu_ri12
    import lsu_ri12_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_aluop,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_reg1_data,
    input  logic [ADDR_W-1:0] in_reg2_data,
    input  logic [4:0]        in_reg_write_addr,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic              dreq_we,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_wstrb,
    output logic [ADDR_W-1:0] dreq_wdata,
    input  logic              dresp_valid,
    input  logic [ADDR_W-1:0] dresp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_reg_write_en,
    output logic [4:0]        out_reg_write_addr,
    output logic [ADDR_W-1:0] out_reg_write_data,
    output logic              out_is_exception,
    output logic [6:0]        out_exception_cause,
    output logic [ADDR_W-1:0] out_badv
);

    lsu_state_e               state;
    wb_pkt_t                  pkt;
    logic [7:0]               op_q;
    logic [1:0]               ea_lo_q;
    logic [ADDR_W-1:0]        pc_q;
    logic [4:0]               dest_q;

    logic signed [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0]        ea_acc;
    logic                     idle;
    logic                     accept;
    logic [3:0]               al_wstrb;
    logic [ADDR_W-1:0]        al_wdata;
    logic [ADDR_W-1:0]        al_load;
    logic                     al_misalign;
    logic                     unused_inst;

    assign unused_inst = ^{in_inst[31:22], in_inst[9:0]};

    assign off_s  = signed'({{(ADDR_W-12){in_inst[21]}}, in_inst[21:10]});
    assign ea_acc = in_reg1_data + off_s;

    assign idle     = (state == S_IDLE);
    assign in_ready = idle;
    assign accept   = idle && in_valid && !flush;

    // In IDLE the lane network sees the incoming op; afterwards the latched one.
    lsu_align u_align (
        .op        (idle ? in_aluop : op_q),
        .ea_lo     (idle ? ea_acc[1:0] : ea_lo_q),
        .rd_data   (in_reg2_data),
        .rdata     (dresp_rdata),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .load_data (al_load),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= in_aluop;
            ea_lo_q <= ea_acc[1:0];
            pc_q    <= in_pc;
            dest_q  <= in_reg_write_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dreq_valid <= 1'b0;
            dreq_we    <= 1'b0;
            dreq_addr  <= '0;
            dreq_wstrb <= 4'b0000;
            dreq_wdata <= '0;
            out_valid  <= 1'b0;
            pkt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!op_legal(in_aluop)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            pkt       <= make_pkt(in_pc, 1'b0, in_reg_write_addr, '0,
                                                  1'b1, EXCEPTION_INE, '0);
                        end else if (al_misalign) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            pkt       <= make_pkt(in_pc, 1'b0, in_reg_write_addr, '0,
                                                  1'b1, EXCEPTION_ALE, ea_acc);
                        end else begin
                            state      <= S_REQ;
                            dreq_valid <= 1'b1;
                            dreq_we    <= is_store_op(in_aluop);
                            dreq_addr  <= ea_acc;
                            dreq_wstrb <= al_wstrb;
                            dreq_wdata <= al_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (flush || dreq_ready) begin
                        dreq_valid <= 1'b0;
                        dreq_we    <= 1'b0;
                        dreq_addr  <= '0;
                        dreq_wstrb <= 4'b0000;
                        dreq_wdata <= '0;
                    end
                    // A load already handed to the dcache must have its response drained.
                    if (flush) begin
                        state <= (dreq_ready && !dreq_we) ? S_DRAIN : S_IDLE;
                    end else if (dreq_ready) begin
                        if (dreq_we) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            pkt       <= make_pkt(pc_q, 1'b0, dest_q, '0, 1'b0, 7'd0, '0);
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= dresp_valid ? S_IDLE : S_DRAIN;
                    end else if (dresp_valid) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        pkt       <= make_pkt(pc_q, 1'b1, dest_q, al_load, 1'b0, 7'd0, '0);
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        pkt       <= '0;
                    end
                end
                S_DRAIN: begin
                    if (dresp_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_pc              = pkt.pc;
    assign out_reg_write_en    = pkt.reg_write_en;
    assign out_reg_write_addr  = pkt.reg_write_addr;
    assign out_reg_write_data  = pkt.reg_write_data;
    assign out_is_exception    = pkt.is_exception;
    assign out_exception_cause = pkt.exception_cause;
    assign out_badv            = pkt.badv;

endmodule

// File: tb/tb_lsu_ri12.sv
// Self-checking bench for lsu_ri12: directed scenarios plus randomized ops
// compared against a behavioural model of the load/store rules.
`timescale 1ns/1ps
module tb_lsu_ri12;
    import lsu_ri12_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [7:0]  in_aluop;
    logic [31:0] in_pc, in_inst, in_reg1_data, in_reg2_data;
    logic [4:0]  in_reg_write_addr;
    logic        dreq_valid, dreq_ready, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        out_valid, out_ready, out_reg_write_en, out_is_exception;
    logic [31:0] out_pc, out_reg_write_data, out_badv;
    logic [4:0]  out_reg_write_addr;
    logic [6:0]  out_exception_cause;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_ri12 #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop), .in_pc(in_pc),
        .in_inst(in_inst), .in_reg1_data(in_reg1_data), .in_reg2_data(in_reg2_data),
        .in_reg_write_addr(in_reg_write_addr),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
        .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_reg_write_en(out_reg_write_en), .out_reg_write_addr(out_reg_write_addr),
        .out_reg_write_data(out_reg_write_data), .out_is_exception(out_is_exception),
        .out_exception_cause(out_exception_cause), .out_badv(out_badv)
    );

    typedef struct packed {
        bit          timeout;
        bit          saw_req;
        int          req_cycles;
        bit          req_unstable;
        logic        req_we;
        logic [31:0] req_addr;
        logic [3:0]  req_wstrb;
        logic [31:0] req_wdata;
        int          out_cycle;
        int          out_cycles;
        bit          out_unstable;
        bit          busy_ready;
        bit          ready_after;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exc;
        logic [6:0]  cause;
        logic [31:0] badv;
    } obs_t;

    typedef struct packed {
        bit          do_req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] load;
        logic        exc;
        logic [6:0]  cause;
        logic [31:0] badv;
    } exp_t;

    // Reference: address arithmetic, access size and lane rules stated directly.
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] rj,
                                   input logic [11:0] si, input logic [31:0] rd,
                                   input logic [31:0] rdata);
        exp_t e;
        int size, lane;
        bit legal, ld, sgn;
        logic [31:0] ea;
        longint unsigned w, lim;
        e = '0; legal = 1; ld = 0; sgn = 0; size = 1;
        ea = rj + {{20{si[11]}}, si};
        case (op)
            ALU_LDB:  begin size = 1; ld = 1; sgn = 1; end
            ALU_LDH:  begin size = 2; ld = 1; sgn = 1; end
            ALU_LDW:  begin size = 4; ld = 1; end
            ALU_LDBU: begin size = 1; ld = 1; end
            ALU_LDHU: begin size = 2; ld = 1; end
            ALU_STB:  size = 1;
            ALU_STH:  size = 2;
            ALU_STW:  size = 4;
            default:  legal = 0;
        endcase
        lane = int'(ea % 4);
        if (!legal) begin
            e.exc = 1; e.cause = EXCEPTION_INE; e.badv = 0;
        end else if ((ea % size) != 0) begin
            e.exc = 1; e.cause = EXCEPTION_ALE; e.badv = ea;
        end else begin
            e.do_req = 1; e.addr = ea; e.we = !ld;
            if (ld) begin
                lim = 64'd1 << (8 * size);
                w = (longint'(rdata) >> (8 * lane)) % lim;
                if (sgn && w >= lim / 2) w = w + (64'd1 << 32) - lim;
                e.load = w[31:0];
                e.wen = 1;
            end else begin
                for (int k = 0; k < size; k++) e.wstrb[lane + k] = 1'b1;
                for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rd[8*(i % size) +: 8];
            end
        end
        return e;
    endfunction

    task automatic offer(input logic [7:0] op, input logic [31:0] rj, input logic [11:0] si,
                         input logic [31:0] rd, input logic [4:0] dst, input logic [31:0] pc);
        logic [31:0] inst;
        inst = $urandom();
        inst[21:10] = si;
        in_valid = 1'b1; in_aluop = op; in_pc = pc; in_inst = inst;
        in_reg1_data = rj; in_reg2_data = rd; in_reg_write_addr = dst;
    endtask

    task automatic scramble();
        in_valid = 1'b0; in_aluop = 8'($urandom()); in_pc = $urandom(); in_inst = $urandom();
        in_reg1_data = $urandom(); in_reg2_data = $urandom(); in_reg_write_addr = 5'($urandom());
    endtask

    // Drives one op end to end, acting as dcache and writeback consumer.
    task automatic do_op(input logic [7:0] op, input logic [31:0] rj, input logic [11:0] si,
                         input logic [31:0] rd, input logic [4:0] dst, input logic [31:0] pc,
                         input logic [31:0] rdata, input int req_delay, input int out_delay,
                         output obs_t o);
        int cyc;
        bit resp_next, done;
        o = '0; resp_next = 0; done = 0;
        @(negedge clk);
        offer(op, rj, si, rd, dst, pc);
        @(negedge clk);
        scramble();
        cyc = 1;
        while (!done && cyc < 80) begin
            dresp_valid = resp_next;
            dresp_rdata = resp_next ? rdata : $urandom();
            resp_next = 0;
            dreq_ready = 1'b0;
            if (dreq_valid) begin
                if (o.req_cycles == 0) begin
                    o.saw_req = 1; o.req_we = dreq_we; o.req_addr = dreq_addr;
                    o.req_wstrb = dreq_wstrb; o.req_wdata = dreq_wdata;
                end else if ({dreq_we, dreq_addr, dreq_wstrb, dreq_wdata} !==
                             {o.req_we, o.req_addr, o.req_wstrb, o.req_wdata}) begin
                    o.req_unstable = 1;
                end
                o.req_cycles++;
                if (o.req_cycles > req_delay) begin
                    dreq_ready = 1'b1;
                    resp_next = !dreq_we;
                end
            end
            if (out_valid) begin
                if (o.out_cycles == 0) begin
                    o.out_cycle = cyc; o.pc = out_pc; o.wen = out_reg_write_en;
                    o.waddr = out_reg_write_addr; o.wdata = out_reg_write_data;
                    o.exc = out_is_exception; o.cause = out_exception_cause; o.badv = out_badv;
                end else if ({out_pc, out_reg_write_en, out_reg_write_addr, out_reg_write_data,
                              out_is_exception, out_exception_cause, out_badv} !==
                             {o.pc, o.wen, o.waddr, o.wdata, o.exc, o.cause, o.badv}) begin
                    o.out_unstable = 1;
                end
                o.out_cycles++;
                out_ready = (o.out_cycles > out_delay);
            end else if (o.out_cycles > 0) begin
                o.ready_after = in_ready;
                done = 1;
            end
            if (!done && in_ready) o.busy_ready = 1;
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        o.timeout = !done;
        out_ready = 1'b0; dreq_ready = 1'b0; dresp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_rdata = '0;
        out_ready = 1'b0; scramble();
        repeat (3) @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dreq_valid: got %b want 0", dreq_valid); end
        n_tests++; if ({dreq_we, dreq_addr, dreq_wstrb, dreq_wdata} !== 69'd0) begin n_fail++; $display("FAIL reset_dreq_fields: got %h want 0", {dreq_we, dreq_addr, dreq_wstrb, dreq_wdata}); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if ({out_pc, out_reg_write_en, out_reg_write_data, out_is_exception, out_exception_cause, out_badv} !== 105'd0) begin n_fail++; $display("FAIL reset_out_fields: got %h want 0", {out_pc, out_reg_write_en, out_reg_write_data, out_is_exception, out_exception_cause, out_badv}); end
        rst = 1'b0;
    endtask

    task automatic test_ld_b();
        obs_t o;
        do_op(ALU_LDB, 32'h0000_1000, 12'hFFF, $urandom(), 5'd7, 32'h1c00_0010, 32'h8011_2233, 0, 0, o);
        n_tests++; if (o.timeout) begin n_fail++; $display("FAIL ldb_timeout: got timeout want completion"); end
        n_tests++; if (o.req_addr !== 32'h0000_0FFF) begin n_fail++; $display("FAIL ldb_addr: got %h want 00000fff", o.req_addr); end
        n_tests++; if (o.req_we !== 1'b0 || o.req_wstrb !== 4'b0000) begin n_fail++; $display("FAIL ldb_we_strb: got %b/%b want 0/0000", o.req_we, o.req_wstrb); end
        n_tests++; if (o.out_cycle != 3) begin n_fail++; $display("FAIL ldb_latency: got %0d want 3", o.out_cycle); end
        n_tests++; if (o.wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_data: got %h want ffffff80", o.wdata); end
        n_tests++; if (o.wen !== 1'b1 || o.waddr !== 5'd7) begin n_fail++; $display("FAIL ldb_wb: got en=%b addr=%0d want en=1 addr=7", o.wen, o.waddr); end
        n_tests++; if (o.pc !== 32'h1c00_0010 || o.exc !== 1'b0) begin n_fail++; $display("FAIL ldb_pc_exc: got %h/%b want 1c000010/0", o.pc, o.exc); end
    endtask

    task automatic test_st_h();
        obs_t o;
        do_op(ALU_STH, 32'h0000_2000, 12'h002, 32'h1234_ABCD, 5'd9, 32'h1c00_0020, $urandom(), 3, 0, o);
        n_tests++; if (o.timeout) begin n_fail++; $display("FAIL sth_timeout: got timeout want completion"); end
        n_tests++; if (o.req_we !== 1'b1 || o.req_addr !== 32'h0000_2002) begin n_fail++; $display("FAIL sth_req: got we=%b addr=%h want we=1 addr=00002002", o.req_we, o.req_addr); end
        n_tests++; if (o.req_wstrb !== 4'b1100 || o.req_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sth_lanes: got %b/%h want 1100/abcdabcd", o.req_wstrb, o.req_wdata); end
        n_tests++; if (o.req_cycles != 4 || o.req_unstable) begin n_fail++; $display("FAIL sth_hold: got cycles=%0d unstable=%b want 4/0", o.req_cycles, o.req_unstable); end
        n_tests++; if (o.wen !== 1'b0 || o.exc !== 1'b0) begin n_fail++; $display("FAIL sth_wb: got en=%b exc=%b want 0/0", o.wen, o.exc); end
    endtask

    task automatic test_ale();
        obs_t o;
        do_op(ALU_LDW, 32'h0000_3000, 12'h002, $urandom(), 5'd4, 32'h1c00_0030, $urandom(), 0, 0, o);
        n_tests++; if (o.saw_req !== 1'b0) begin n_fail++; $display("FAIL ale_noreq: got dreq=%b want 0", o.saw_req); end
        n_tests++; if (o.exc !== 1'b1 || o.cause !== EXCEPTION_ALE) begin n_fail++; $display("FAIL ale_cause: got exc=%b cause=%h want 1/%h", o.exc, o.cause, EXCEPTION_ALE); end
        n_tests++; if (o.badv !== 32'h0000_3002 || o.wen !== 1'b0) begin n_fail++; $display("FAIL ale_badv: got %h en=%b want 00003002 en=0", o.badv, o.wen); end
    endtask

    task automatic test_ld_hu_backpressure();
        obs_t o;
        do_op(ALU_LDHU, 32'h0000_4000, 12'h002, $urandom(), 5'd12, 32'h1c00_0040, 32'hBEEF_0000, 0, 4, o);
        n_tests++; if (o.wdata !== 32'h0000_BEEF || o.wen !== 1'b1) begin n_fail++; $display("FAIL ldhu_data: got %h en=%b want 0000beef en=1", o.wdata, o.wen); end
        n_tests++; if (o.out_cycles != 5 || o.out_unstable) begin n_fail++; $display("FAIL ldhu_hold: got cycles=%0d unstable=%b want 5/0", o.out_cycles, o.out_unstable); end
        n_tests++; if (o.busy_ready !== 1'b0 || o.ready_after !== 1'b1) begin n_fail++; $display("FAIL ldhu_in_ready: got busy=%b after=%b want 0/1", o.busy_ready, o.ready_after); end
    endtask

    task automatic test_flush_wait();
        obs_t o;
        exp_t e;
        @(negedge clk);
        offer(ALU_LDW, 32'h0000_5000, 12'h004, 32'h0, 5'd3, 32'h1c00_0050);
        @(negedge clk);
        scramble();
        n_tests++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL flw_req: got %b want 1", dreq_valid); end
        dreq_ready = 1'b1;
        @(negedge clk);
        dreq_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flw_drain1: got rdy=%b ov=%b want 0/0", in_ready, out_valid); end
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flw_drain2: got rdy=%b want 0", in_ready); end
        dresp_valid = 1'b1; dresp_rdata = $urandom();
        @(negedge clk);
        dresp_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flw_idle: got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
        e = model(ALU_LDB, 32'h0000_6000, 12'h002, 32'h0, 32'h44CC_7711);
        do_op(ALU_LDB, 32'h0000_6000, 12'h002, 32'h0, 5'd5, 32'h1c00_0054, 32'h44CC_7711, 0, 0, o);
        n_tests++; if (o.timeout || o.wdata !== e.load || o.wen !== 1'b1) begin n_fail++; $display("FAIL flw_next: got %h en=%b to=%b want %h en=1", o.wdata, o.wen, o.timeout, e.load); end
    endtask

    task automatic test_flush_misc();
        // Flush coincident with accept drops the op.
        @(negedge clk);
        offer(ALU_LDW, 32'h0000_7000, 12'h000, 32'h0, 5'd1, 32'h1c00_0060);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; scramble();
        n_tests++; if (in_ready !== 1'b1 || dreq_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_accept: got rdy=%b dv=%b ov=%b want 1/0/0", in_ready, dreq_valid, out_valid); end
        // Flush in REQ with a load handshake must drain the response.
        @(negedge clk);
        offer(ALU_LDW, 32'h0000_7000, 12'h008, 32'h0, 5'd1, 32'h1c00_0064);
        @(negedge clk);
        scramble(); flush = 1'b1; dreq_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; dreq_ready = 1'b0;
        n_tests++; if (in_ready !== 1'b0 || dreq_valid !== 1'b0) begin n_fail++; $display("FAIL fl_req_load: got rdy=%b dv=%b want 0/0", in_ready, dreq_valid); end
        flush = 1'b1; dresp_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; dresp_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drain_done: got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
        // Flush in REQ without handshake returns straight to idle.
        @(negedge clk);
        offer(ALU_STW, 32'h0000_7000, 12'h00C, 32'h5, 5'd1, 32'h1c00_0068);
        @(negedge clk);
        scramble(); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (in_ready !== 1'b1 || dreq_valid !== 1'b0) begin n_fail++; $display("FAIL fl_req_nohs: got rdy=%b dv=%b want 1/0", in_ready, dreq_valid); end
        // Flush in DONE kills the packet.
        @(negedge clk);
        offer(ALU_LDH, 32'h0000_7001, 12'h000, 32'h0, 5'd1, 32'h1c00_006c);
        @(negedge clk);
        scramble();
        n_tests++; if (out_valid !== 1'b1 || out_is_exception !== 1'b1) begin n_fail++; $display("FAIL fl_done_pre: got ov=%b exc=%b want 1/1", out_valid, out_is_exception); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_is_exception !== 1'b0) begin n_fail++; $display("FAIL fl_done: got ov=%b rdy=%b exc=%b want 0/1/0", out_valid, in_ready, out_is_exception); end
    endtask

    task automatic test_ine_and_rst();
        obs_t o;
        do_op(ALU_ORI, 32'h0000_8000, 12'h010, $urandom(), 5'd2, 32'h1c00_0070, $urandom(), 0, 0, o);
        n_tests++; if (o.saw_req !== 1'b0) begin n_fail++; $display("FAIL ine_noreq: got dreq=%b want 0", o.saw_req); end
        n_tests++; if (o.exc !== 1'b1 || o.cause !== EXCEPTION_INE || o.badv !== 32'h0) begin n_fail++; $display("FAIL ine_cause: got exc=%b cause=%h badv=%h want 1/%h/0", o.exc, o.cause, o.badv, EXCEPTION_INE); end
        @(negedge clk);
        offer(ALU_STW, 32'h0000_9000, 12'h000, 32'hCAFE_F00D, 5'd2, 32'h1c00_0074);
        @(negedge clk);
        scramble();
        n_tests++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre: got %b want 1", dreq_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req: got dv=%b rdy=%b want 0/1", dreq_valid, in_ready); end
    endtask

    task automatic test_random();
        logic [7:0] ops [9];
        obs_t o;
        exp_t e;
        logic [7:0] op;
        logic [31:0] rj, rd, rdata, pc, ea0;
        logic [11:0] si;
        logic [4:0] dst;
        ops = '{ALU_LDB, ALU_LDH, ALU_LDW, ALU_LDBU, ALU_LDHU, ALU_STB, ALU_STH, ALU_STW, ALU_ORI};
        for (int it = 0; it < 40; it++) begin
            op = ops[$urandom_range(0, 8)];
            rj = $urandom(); si = 12'($urandom()); rd = $urandom(); rdata = $urandom();
            pc = $urandom(); dst = 5'($urandom());
            if ($urandom_range(0, 2) != 0) begin
                ea0 = rj + {{20{si[11]}}, si};
                rj = rj - (ea0 & 32'h3);
            end
            e = model(op, rj, si, rd, rdata);
            do_op(op, rj, si, rd, dst, pc, rdata, $urandom_range(0, 2), $urandom_range(0, 2), o);
            n_tests++; if (o.timeout || o.saw_req !== e.do_req) begin n_fail++; $display("FAIL rnd%0d_req: got req=%b to=%b want req=%b", it, o.saw_req, o.timeout, e.do_req); end
            if (e.do_req) begin
                n_tests++; if (o.req_we !== e.we || o.req_addr !== e.addr || o.req_wstrb !== e.wstrb || o.req_unstable) begin n_fail++; $display("FAIL rnd%0d_dreq: got we=%b a=%h s=%b u=%b want we=%b a=%h s=%b", it, o.req_we, o.req_addr, o.req_wstrb, o.req_unstable, e.we, e.addr, e.wstrb); end
                if (e.we) begin
                    n_tests++; if (o.req_wdata !== e.wdata) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o.req_wdata, e.wdata); end
                end
            end
            n_tests++; if (o.exc !== e.exc || o.cause !== e.cause || o.badv !== e.badv || o.wen !== e.wen) begin n_fail++; $display("FAIL rnd%0d_pkt: got exc=%b c=%h bv=%h en=%b want exc=%b c=%h bv=%h en=%b", it, o.exc, o.cause, o.badv, o.wen, e.exc, e.cause, e.badv, e.wen); end
            if (e.wen) begin
                n_tests++; if (o.wdata !== e.load || o.waddr !== dst) begin n_fail++; $display("FAIL rnd%0d_load: got %h rd%0d want %h rd%0d", it, o.wdata, o.waddr, e.load, dst); end
            end
            n_tests++; if (o.pc !== pc || o.busy_ready !== 1'b0 || o.ready_after !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ctl: got pc=%h busy=%b after=%b want pc=%h 0/1", it, o.pc, o.busy_ready, o.ready_after, pc); end
        end
    endtask

    initial begin
        test_reset();
        test_ld_b();
        test_st_h();
        test_ale();
        test_ld_hu_backpressure();
        test_flush_wait();
        test_flush_misc();
        test_ine_and_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ri12.md
Name: lsu_ri12

Overview:
- Load/store execution unit that consumes the 2RI12-format memory ops produced by the decode stage: LD.B, LD.H, LD.W, LD.BU, LD.HU, ST.B, ST.H, ST.W.
- Computes the effective address, checks alignment, and issues one request at a time to the data cache over a valid/ready handshake.
- Aligns and extends load data, then returns a writeback packet to the pipeline.
- Single outstanding op; sits between the issue/execute stage and the dcache port.

Parameters:
- ADDR_W, 32, address/data width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush; kills the op in flight
- in_valid  in  1  op offered by issue stage
- in_ready  out  1  unit can accept; high only in IDLE
- in_aluop  in  8  ALU_LDB/LDH/LDW/LDBU/LDHU/STB/STH/STW; other codes are illegal
- in_pc  in  32  PC of the op
- in_inst  in  32  raw instruction; si12 = in_inst[21:10]
- in_reg1_data  in  32  rj value (base)
- in_reg2_data  in  32  rd value (store data)
- in_reg_write_addr  in  5  load destination
- dreq_valid  out  1  dcache request valid
- dreq_ready  in  1  dcache accepts request
- dreq_we  out  1  1 = store
- dreq_addr  out  32  byte address
- dreq_wstrb  out  4  byte strobes; 0 for loads
- dreq_wdata  out  32  replicated store data
- dresp_valid  in  1  load data valid; one pulse per load request
- dresp_rdata  in  32  word containing the addressed bytes
- out_valid  out  1  writeback packet valid
- out_ready  in  1  downstream accepts packet
- out_pc  out  32  PC of completed op
- out_reg_write_en  out  1  1 for a load with no exception
- out_reg_write_addr  out  5  destination register
- out_reg_write_data  out  32  extended load data
- out_is_exception  out  1  op raised an exception
- out_exception_cause  out  7  EXCEPTION_ALE or EXCEPTION_INE
- out_badv  out  32  faulting effective address; 0 for INE

Behaviour:
- Reset: state=IDLE, in_ready=1, all other outputs 0 (dreq_*, out_*).
- Effective address: ea = in_reg1_data + sext(si12), wrapping mod 2^32. Computed and registered at accept, together with op, pc, rd data and dest.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - On in_valid&&in_ready, latch the op.
  - Illegal aluop -> DONE, INE.
  - Misaligned -> DONE, ALE; no dcache request. Misaligned means H-ops with ea[0]=1, or W-ops with ea[1:0]!=0.
  - Otherwise -> REQ.
- REQ:
  - dreq_valid=1; addr/we/wstrb/wdata held stable until dreq_ready.
  - On handshake: loads -> WAIT, stores -> DONE.
- WAIT: on dresp_valid, capture the extracted data and go to DONE.
- Load extract: byte = rdata >> (8*ea[1:0]); half = rdata >> (8*ea[1:0]). LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend; LD.W passes the word.
- Store generation:
  - ST.B: wstrb=4'b0001<<ea[1:0], wdata={4{rd[7:0]}}.
  - ST.H: wstrb=4'b0011<<ea[1:0], wdata={2{rd[15:0]}}.
  - ST.W: wstrb=4'b1111, wdata=rd.
- DONE: out_valid=1, outputs stable until out_ready; then -> IDLE. There is no bypass: a new op is accepted at the earliest one cycle after DONE exits.
- Latency (aligned load, dcache ready and response in the next cycle): accept at cycle 0, dreq at 1, dresp at 2, out_valid at 3.
- Flush:
  - IDLE/REQ(no handshake)/DONE -> IDLE next cycle, outputs cleared.
  - A flush in the same cycle as an accept discards the accept.
  - REQ handshake in the flush cycle counts as issued: a store is not undone -> IDLE; a load -> DRAIN.
  - WAIT -> DRAIN, or IDLE if dresp_valid arrives in that same cycle.
  - DRAIN: in_ready=0; discard the next dresp_valid, then -> IDLE.
  - A flush while in DRAIN is ignored.
- rst mid-operation: state returns to IDLE. The dcache is reset in the same cycle, so no drain is needed.
- dresp_valid outside WAIT/DRAIN is ignored.

Decomposition:
- Shared defines (defines.vh / csr_defines.vh): ALU_LD*/ALU_ST* opcodes, EXCEPTION_ALE and EXCEPTION_INE encodings, state encoding localparams.
- Sub-module lsu_align: combinational; op + ea[1:0] + rd/rdata -> wstrb, wdata, load result, misalign flag.
- lsu_ri12 holds the FSM and registers.

Test Plan:
- LD.B, rj=0x1000, si12=0xFFF (ea=0x0FFF), dresp_rdata=0x80112233 -> dreq_addr=0x0FFF, out_reg_write_data=0xFFFFFF80, write_en=1, out_valid at cycle 3.
- ST.H, rj=0x2000, si12=2, rd=0x1234ABCD -> dreq_we=1, wstrb=4'b1100, wdata=0xABCDABCD; dreq_valid held 3 cycles with dreq_ready low; out_valid with write_en=0.
- LD.W, ea=0x3002 -> no dreq_valid; out_is_exception=1, cause=EXCEPTION_ALE, out_badv=0x3002, write_en=0.
- LD.HU, ea=0x4002, rdata=0xBEEF0000 -> write_data=0x0000BEEF. Hold out_ready=0 for 4 cycles: packet stable, in_ready=0.
- LD.W issued, flush during WAIT, dresp 2 cycles later -> no out_valid; in_ready=0 until the dresp cycle, then 1. Next op decodes correctly.
- aluop=ALU_ORI offered -> out_is_exception=1, cause=EXCEPTION_INE, no dcache traffic. rst asserted in REQ -> dreq_valid=0 next cycle, in_ready=1.
